// File: rtl/diff_square_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : diff_square_acc_pkg                                              |
// | Shared constants for the PCMA squared-distance accumulator: mode codes,    |
// | ideal constellation points (first quadrant/octant) and the fold selector.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package diff_square_acc_pkg;

  // Mode codes as presented on mode_i
  localparam logic [2:0] c_MODE_BPSK = 3'b000;
  localparam logic [2:0] c_MODE_QPSK = 3'b001;
  localparam logic [2:0] c_MODE_8PSK = 3'b010;

  // Ideal points after folding: (major axis, minor axis)
  localparam int c_BPSK_I = 256;
  localparam int c_BPSK_Q = 0;
  localparam int c_QPSK_I = 180;
  localparam int c_QPSK_Q = 180;
  localparam int c_8PSK_I = 256;
  localparam int c_8PSK_Q = 98;

  // Folding rule carried down the pipeline with each sample
  typedef enum logic [1:0] {
    FOLD_BPSK = 2'd0,
    FOLD_QPSK = 2'd1,
    FOLD_8PSK = 2'd2
  } fold_e;

  // Reserved mode codes fall back to the 8-PSK rule
  function automatic fold_e mode_to_fold(input logic [2:0] mode);
    case (mode)
      c_MODE_BPSK: return FOLD_BPSK;
      c_MODE_QPSK: return FOLD_QPSK;
      default:     return FOLD_8PSK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/diff_square_acc_sym_err.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : diff_square_acc_sym_err                                          |
// | Per-symbol squared error to the nearest ideal PCMA point, 5-stage pipeline |
// | S1 register, S2 saturating abs, S3 fold + distance, S4 squares, S5 sum.    |
// | Ports   : clk, reset_n (async, active low), flush_i (clears valids),       |
// |           in_val_i/in_last_i/in_fold_i/in_i_data_i/in_q_data_i (sample),   |
// |           out_val_o/out_last_o/err_o (result, 5 cycles later)              |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module diff_square_acc_sym_err
  import diff_square_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic                         in_val_i,
  input  logic                         in_last_i,
  input  fold_e                        in_fold_i,
  input  logic signed [DATA_WIDTH-1:0] in_i_data_i,
  input  logic signed [DATA_WIDTH-1:0] in_q_data_i,
  output logic                         out_val_o,
  output logic                         out_last_o,
  output logic [2*DATA_WIDTH-1:0]      err_o
);

  localparam int c_ERR_W = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] c_ABS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_BPSK_I_U = DATA_WIDTH'(c_BPSK_I);
  localparam logic [DATA_WIDTH-1:0] c_BPSK_Q_U = DATA_WIDTH'(c_BPSK_Q);
  localparam logic [DATA_WIDTH-1:0] c_QPSK_I_U = DATA_WIDTH'(c_QPSK_I);
  localparam logic [DATA_WIDTH-1:0] c_QPSK_Q_U = DATA_WIDTH'(c_QPSK_Q);
  localparam logic [DATA_WIDTH-1:0] c_8PSK_I_U = DATA_WIDTH'(c_8PSK_I);
  localparam logic [DATA_WIDTH-1:0] c_8PSK_Q_U = DATA_WIDTH'(c_8PSK_Q);

  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] neg;
    neg = -x;
    if (!x[DATA_WIDTH-1])        abs_sat = x;
    else if (neg[DATA_WIDTH-1])  abs_sat = c_ABS_MAX;  // most-negative value has no positive twin
    else                         abs_sat = neg;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] abs_diff(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

  // Pipeline control
  logic r_v1, r_v2, r_v3, r_v4, r_v5;
  logic r_l1, r_l2, r_l3, r_l4, r_l5;
  // Pipeline data
  fold_e                        r_f1, r_f2;
  logic signed [DATA_WIDTH-1:0] r_i1, r_q1;
  logic [DATA_WIDTH-1:0]        r_ai2, r_aq2;
  logic [DATA_WIDTH-1:0]        r_da3, r_dq3;
  logic [c_ERR_W-1:0]           r_sqi4, r_sqq4;
  logic [c_ERR_W-1:0]           r_err5;

  logic [DATA_WIDTH-1:0] w_hi, w_lo, w_ref_hi, w_ref_lo;
  logic [c_ERR_W-1:0]    w_di_ext, w_dq_ext;

  // Fold: the distance to the ideal point only depends on the folded magnitudes.
  always_comb begin
    w_hi     = r_ai2;
    w_lo     = r_aq2;
    w_ref_hi = c_QPSK_I_U;
    w_ref_lo = c_QPSK_Q_U;
    case (r_f2)
      FOLD_BPSK: begin
        w_ref_hi = c_BPSK_I_U;
        w_ref_lo = c_BPSK_Q_U;
      end
      FOLD_QPSK: begin
        w_ref_hi = c_QPSK_I_U;
        w_ref_lo = c_QPSK_Q_U;
      end
      default: begin
        if (r_ai2 < r_aq2) begin
          w_hi = r_aq2;
          w_lo = r_ai2;
        end
        w_ref_hi = c_8PSK_I_U;
        w_ref_lo = c_8PSK_Q_U;
      end
    endcase
  end

  // The signed difference is only ever squared, so its magnitude is kept instead;
  // every distance fits in DATA_WIDTH bits unsigned.
  assign w_di_ext = {{DATA_WIDTH{1'b0}}, r_da3};
  assign w_dq_ext = {{DATA_WIDTH{1'b0}}, r_dq3};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {r_v1, r_v2, r_v3, r_v4, r_v5} <= '0;
      {r_l1, r_l2, r_l3, r_l4, r_l5} <= '0;
    end else if (flush_i) begin
      {r_v1, r_v2, r_v3, r_v4, r_v5} <= '0;
      {r_l1, r_l2, r_l3, r_l4, r_l5} <= '0;
    end else begin
      r_v1 <= in_val_i;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
      r_v5 <= r_v4;
      r_l1 <= in_val_i & in_last_i;
      r_l2 <= r_l1;
      r_l3 <= r_l2;
      r_l4 <= r_l3;
      r_l5 <= r_l4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f1   <= FOLD_QPSK;
      r_f2   <= FOLD_QPSK;
      r_i1   <= '0;
      r_q1   <= '0;
      r_ai2  <= '0;
      r_aq2  <= '0;
      r_da3  <= '0;
      r_dq3  <= '0;
      r_sqi4 <= '0;
      r_sqq4 <= '0;
      r_err5 <= '0;
    end else begin
      r_f1   <= in_fold_i;
      r_i1   <= in_i_data_i;
      r_q1   <= in_q_data_i;
      r_f2   <= r_f1;
      r_ai2  <= abs_sat(r_i1);
      r_aq2  <= abs_sat(r_q1);
      r_da3  <= abs_diff(w_hi, w_ref_hi);
      r_dq3  <= abs_diff(w_lo, w_ref_lo);
      r_sqi4 <= w_di_ext * w_di_ext;
      r_sqq4 <= w_dq_ext * w_dq_ext;
      r_err5 <= r_sqi4 + r_sqq4;
    end
  end

  assign out_val_o  = r_v5;
  assign out_last_o = r_l5;
  assign err_o      = r_err5;

endmodule
`default_nettype wire

// File: rtl/diff_square_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : diff_square_acc                                                  |
// | Windowed sum of per-symbol squared distance to the nearest PCMA point.     |
// | Ports   : clk, reset_n (async, active low), mode_i, win_log2_i, enable_i,  |
// |           data_val_i, I_data_i, Q_data_i (inputs); err_val_o, err_o        |
// |           (per-symbol stream); acc_valid_o, acc_ready_i, acc_o (window     |
// |           result handshake); overrun_o (sticky lost-result flag)           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module diff_square_acc
  import diff_square_acc_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter int ACC_WIDTH    = 32,
  parameter int WIN_MAX_LOG2 = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [2:0]                   mode_i,
  input  logic [4:0]                   win_log2_i,
  input  logic                         enable_i,
  input  logic                         data_val_i,
  input  logic signed [DATA_WIDTH-1:0] I_data_i,
  input  logic signed [DATA_WIDTH-1:0] Q_data_i,
  output logic                         err_val_o,
  output logic [2*DATA_WIDTH-1:0]      err_o,
  output logic                         acc_valid_o,
  input  logic                         acc_ready_i,
  output logic [ACC_WIDTH-1:0]         acc_o,
  output logic                         overrun_o
);

  localparam int c_ERR_W = 2 * DATA_WIDTH;
  localparam int c_CNT_W = WIN_MAX_LOG2 + 1;
  localparam int c_SW    = ((ACC_WIDTH > c_ERR_W) ? ACC_WIDTH : c_ERR_W) + 1;
  localparam logic [4:0]           c_WIN_MAX     = 5'(WIN_MAX_LOG2);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [ACC_WIDTH-1:0] c_ACC_MAX     = '1;
  localparam logic [c_SW-1:0]      c_ACC_MAX_EXT = c_SW'(c_ACC_MAX);

  // ---------------- window membership, decided at sample entry ----------------
  // Each sample is tagged on entry with its window's mode and with whether it is
  // the window's final symbol, so mode and window boundaries always agree even
  // while earlier samples are still in flight.
  logic               r_open;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_mode_lat;
  logic [4:0]         r_win_lat;

  logic               w_accept;
  logic [4:0]         w_win_req, w_win_eff;
  logic [2:0]         w_mode_eff;
  logic [c_CNT_W-1:0] w_cnt_eff, w_target;
  logic               w_in_last;

  assign w_accept   = enable_i & data_val_i;
  assign w_win_req  = (win_log2_i > c_WIN_MAX) ? c_WIN_MAX : win_log2_i;
  assign w_mode_eff = r_open ? r_mode_lat : mode_i;
  assign w_win_eff  = r_open ? r_win_lat  : w_win_req;
  assign w_cnt_eff  = r_open ? r_cnt      : '0;
  assign w_target   = (c_CNT_ONE << w_win_eff) - c_CNT_ONE;
  assign w_in_last  = (w_cnt_eff == w_target);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open     <= 1'b0;
      r_cnt      <= '0;
      r_mode_lat <= c_MODE_QPSK;
      r_win_lat  <= '0;
    end else if (!enable_i) begin
      r_open <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      if (!r_open) begin
        r_mode_lat <= mode_i;
        r_win_lat  <= w_win_req;
      end
      if (w_in_last) begin
        r_open <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_open <= 1'b1;
        r_cnt  <= w_cnt_eff + c_CNT_ONE;
      end
    end
  end

  // ---------------- per-symbol error pipeline ----------------
  logic               w_pipe_val, w_pipe_last, w_err_val;
  logic [c_ERR_W-1:0] w_err;

  diff_square_acc_sym_err #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sym_err (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (!enable_i),
    .in_val_i    (w_accept),
    .in_last_i   (w_in_last),
    .in_fold_i   (mode_to_fold(w_mode_eff)),
    .in_i_data_i (I_data_i),
    .in_q_data_i (Q_data_i),
    .out_val_o   (w_pipe_val),
    .out_last_o  (w_pipe_last),
    .err_o       (w_err)
  );

  // Masked with enable_i so nothing is reported in the cycle enable drops.
  assign w_err_val = w_pipe_val & enable_i;

  // ---------------- saturating accumulator and result handshake ----------------
  logic [ACC_WIDTH-1:0] r_acc, r_acc_out;
  logic                 r_acc_valid, r_overrun;
  logic [c_SW-1:0]      w_sum;
  logic [ACC_WIDTH-1:0] w_sat;

  assign w_sum = c_SW'(r_acc) + c_SW'(w_err);
  assign w_sat = (w_sum > c_ACC_MAX_EXT) ? c_ACC_MAX : w_sum[ACC_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_acc_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (!enable_i) begin
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_err_val && w_pipe_last) begin
      // Window closes: publish and restart in the same cycle so no symbol is lost.
      r_acc_out   <= w_sat;
      r_acc_valid <= 1'b1;
      r_acc       <= '0;
      if (r_acc_valid && !acc_ready_i) begin
        r_overrun <= 1'b1;
      end
    end else begin
      if (w_err_val) begin
        r_acc <= w_sat;
      end
      if (r_acc_valid && acc_ready_i) begin
        r_acc_valid <= 1'b0;
      end
    end
  end

  assign err_val_o   = w_err_val;
  assign err_o       = w_err;
  assign acc_valid_o = r_acc_valid;
  assign acc_o       = r_acc_out;
  assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_diff_square_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_diff_square_acc                                               |
// | Self-checking bench: directed cases plus randomized traffic compared with  |
// | an arithmetic reference model of the windowed squared-error sum.           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_diff_square_acc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mode_i;
  logic [4:0]  win_log2_i;
  logic        enable_i;
  logic        data_val_i;
  logic [9:0]  I_data_i;
  logic [9:0]  Q_data_i;
  logic        acc_ready_i;
  logic        err_val_o, acc_valid_o, overrun_o;
  logic [19:0] err_o;
  logic [31:0] acc_o;
  logic        err_val16, acc_valid16, overrun16;
  logic [19:0] err16;
  logic [15:0] acc16;

  always #5 clk = ~clk;

  diff_square_acc dut (
    .clk(clk), .reset_n(reset_n), .mode_i(mode_i), .win_log2_i(win_log2_i),
    .enable_i(enable_i), .data_val_i(data_val_i), .I_data_i(I_data_i), .Q_data_i(Q_data_i),
    .err_val_o(err_val_o), .err_o(err_o), .acc_valid_o(acc_valid_o),
    .acc_ready_i(acc_ready_i), .acc_o(acc_o), .overrun_o(overrun_o)
  );

  diff_square_acc #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .mode_i(mode_i), .win_log2_i(win_log2_i),
    .enable_i(enable_i), .data_val_i(data_val_i), .I_data_i(I_data_i), .Q_data_i(Q_data_i),
    .err_val_o(err_val16), .err_o(err16), .acc_valid_o(acc_valid16),
    .acc_ready_i(acc_ready_i), .acc_o(acc16), .overrun_o(overrun16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint ref_err(input int mode, input int i, input int q);
    int ai, aq, hi, lo, di, dq;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    if (ai > 511) ai = 511;
    if (aq > 511) aq = 511;
    case (mode)
      0: begin di = ai - 256; dq = aq; end
      1: begin di = ai - 180; dq = aq - 180; end
      default: begin
        hi = (ai > aq) ? ai : aq;
        lo = (ai > aq) ? aq : ai;
        di = hi - 256;
        dq = lo - 98;
      end
    endcase
    return longint'(di * di + dq * dq);
  endfunction

  function automatic longint sat_add(input longint a, input longint e, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (a + e > m) ? m : a + e;
  endfunction

  typedef struct {
    int     due;
    longint err;
    bit     last;
    longint s32;
    longint s16;
  } ent_t;

  ent_t   pend[$];
  ent_t   prev;
  bit     prev_v;
  bit     m_av, m_ov;
  longint m_a32, m_a16;
  int     w_pos, w_mode, w_log;
  longint w_s32, w_s16;
  int     cyc;
  bit     mon_on;

  // Observations of the DUT, used by the directed checks
  longint obs_err;
  int     obs_nacc;
  longint obs_acc, obs_acc16, obs_pacc, obs_pacc16;
  bit     obs_pv;

  task automatic model_reset();
    pend.delete();
    prev_v = 0; m_av = 0; m_ov = 0; m_a32 = 0; m_a16 = 0;
    w_pos = 0; w_s32 = 0; w_s16 = 0; w_mode = 1; w_log = 0;
    obs_pv = 0;
  endtask

  // Runs 1 time unit after each rising edge; inputs seen now are those the edge used.
  task automatic step();
    ent_t e;
    cyc++;
    if (enable_i && obs_pv && acc_ready_i) begin
      obs_nacc++;
      obs_acc   = obs_pacc;
      obs_acc16 = obs_pacc16;
    end
    if (!enable_i) begin
      pend.delete();
      prev_v = 0; m_av = 0; m_ov = 0;
      w_pos = 0; w_s32 = 0; w_s16 = 0;
    end else begin
      if (prev_v && prev.last) begin
        if (m_av && !acc_ready_i) m_ov = 1;
        m_av  = 1;
        m_a32 = prev.s32;
        m_a16 = prev.s16;
      end else if (m_av && acc_ready_i) begin
        m_av = 0;
      end
      if (data_val_i) begin
        if (w_pos == 0) begin
          w_mode = int'(mode_i);
          w_log  = (win_log2_i > 16) ? 16 : int'(win_log2_i);
          w_s32  = 0;
          w_s16  = 0;
        end
        e.err  = ref_err(w_mode, int'($signed(I_data_i)), int'($signed(Q_data_i)));
        w_s32  = sat_add(w_s32, e.err, 32);
        w_s16  = sat_add(w_s16, e.err, 16);
        w_pos++;
        e.last = (w_pos == (1 << w_log));
        e.s32  = w_s32;
        e.s16  = w_s16;
        e.due  = cyc + 4;
        if (e.last) w_pos = 0;
        pend.push_back(e);
      end
    end
    prev_v = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      prev   = pend.pop_front();
      prev_v = 1;
    end
    check("err_val", err_val_o, prev_v);
    check("err_val16", err_val16, prev_v);
    if (prev_v) begin
      check("err", err_o, prev.err);
      check("err16", err16, prev.err);
    end
    check("acc_valid", acc_valid_o, m_av);
    check("acc_valid16", acc_valid16, m_av);
    if (m_av) begin
      check("acc", acc_o, m_a32);
      check("acc16", acc16, m_a16);
    end
    check("overrun", overrun_o, m_ov);
    check("overrun16", overrun16, m_ov);
    if (err_val_o) obs_err = err_o;
    obs_pv     = acc_valid_o;
    obs_pacc   = acc_o;
    obs_pacc16 = acc16;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [2:0] m, input int i, input int q);
    @(negedge clk);
    mode_i     = m;
    I_data_i   = 10'(i);
    Q_data_i   = 10'(q);
    data_val_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_val_i = 1'b0;
    end
  endtask

  task automatic flush();
    @(negedge clk);
    enable_i   = 1'b0;
    data_val_i = 1'b0;
    @(negedge clk);
    enable_i   = 1'b1;
  endtask

  task automatic one(input string tag, input logic [2:0] m, input int i, input int q,
                     input longint exp);
    obs_err = -1;
    send(m, i, q);
    idle(7);
    check(tag, obs_err, exp);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_err_val"}, err_val_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_acc_valid"}, acc_valid_o, 0);
    check({tag, "_acc"}, acc_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin
    cyc = 0; mon_on = 0; obs_nacc = 0; obs_err = -1;
    obs_acc = 0; obs_acc16 = 0; obs_pacc = 0; obs_pacc16 = 0;
    reset_n = 1'b0; enable_i = 1'b0; data_val_i = 1'b0; acc_ready_i = 1'b1;
    mode_i = 3'b001; win_log2_i = 5'd0; I_data_i = '0; Q_data_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    mon_on = 1;
    enable_i = 1'b1;

    // Single-symbol windows, per-symbol error values
    win_log2_i = 5'd0;
    one("qpsk_on_point", 3'b001,  180, -180,      0);
    one("qpsk_500",      3'b001, -200,  170,    500);
    one("qpsk_abs_sat",  3'b001, -512,    0, 141961);
    one("8psk_swap",     3'b010,   98, -256,      0);
    one("8psk_11540",    3'b010,  300,    0,  11540);
    one("bpsk_i300",     3'b000,  300,  -40,   3536);

    // Two windows of 4, consumer always ready
    flush();
    win_log2_i = 5'd2; acc_ready_i = 1'b1; obs_nacc = 0;
    repeat (8) send(3'b001, -200, 170);
    idle(8);
    check("win_ready_count", obs_nacc, 2);
    check("win_ready_acc", obs_acc, 2000);
    check("win_ready_overrun", overrun_o, 0);

    // Same with consumer stalled: second window overwrites and flags overrun
    flush();
    acc_ready_i = 1'b0;
    repeat (8) send(3'b001, -200, 170);
    idle(8);
    check("stall_valid", acc_valid_o, 1);
    check("stall_acc", acc_o, 2000);
    check("stall_overrun", overrun_o, 1);
    @(negedge clk) acc_ready_i = 1'b1;
    idle(2);

    // Enable drop mid-window discards the partial window
    flush();
    obs_nacc = 0;
    repeat (3) send(3'b001, -200, 170);
    @(negedge clk);
    enable_i = 1'b0; data_val_i = 1'b0;
    @(negedge clk);
    enable_i = 1'b1;
    repeat (4) send(3'b001, -200, 170);
    idle(8);
    check("reenable_count", obs_nacc, 1);
    check("reenable_acc", obs_acc, 2000);

    // Saturation of the 16-bit accumulator
    flush();
    win_log2_i = 5'd4; obs_nacc = 0;
    repeat (16) send(3'b001, -512, 0);
    idle(8);
    check("sat_count", obs_nacc, 1);
    check("sat_acc32", obs_acc, 2271376);
    check("sat_acc16", obs_acc16, 65535);

    // Asynchronous reset mid-window with a held result
    flush();
    acc_ready_i = 1'b0; win_log2_i = 5'd0;
    send(3'b001, -200, 170);
    win_log2_i = 5'd3;
    idle(6);
    repeat (3) send(3'b001, -200, 170);
    @(posedge clk);
    #2;
    mon_on = 0;
    reset_n = 1'b0;
    data_val_i = 1'b0;
    #1 check_reset_zero("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    mon_on = 1;
    acc_ready_i = 1'b1; win_log2_i = 5'd1; obs_nacc = 0;
    repeat (2) send(3'b001, -200, 170);
    idle(8);
    check("post_reset_count", obs_nacc, 1);
    check("post_reset_acc", obs_acc, 1000);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      enable_i    = ($urandom_range(0, 59) != 0);
      data_val_i  = ($urandom_range(0, 9) < 7);
      acc_ready_i = ($urandom_range(0, 9) < 6);
      mode_i      = 3'($urandom_range(0, 7));
      win_log2_i  = 5'($urandom_range(0, 3));
      I_data_i    = ($urandom_range(0, 15) == 0) ? 10'h200 : 10'($urandom_range(0, 1023));
      Q_data_i    = ($urandom_range(0, 15) == 0) ? 10'h200 : 10'($urandom_range(0, 1023));
    end
    @(negedge clk) enable_i = 1'b1;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
